// File: rtl/vga_draw_pkg.sv
// Shared definitions for the rectangle draw engine: mode encodings, FSM states
// and the standard adapter resolutions.
package vga_draw_pkg;

   localparam logic [1:0] MODE_FILL    = 2'b00;
   localparam logic [1:0] MODE_OUTLINE = 2'b01;
   localparam logic [1:0] MODE_CLEAR   = 2'b10;
   localparam logic [1:0] MODE_RSVD    = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } draw_state_t;

   localparam int RES_160_X_MAX = 159;
   localparam int RES_160_Y_MAX = 119;
   localparam int RES_320_X_MAX = 319;
   localparam int RES_320_Y_MAX = 239;

   function automatic logic is_clear(input logic [1:0] m);
      return (m == MODE_CLEAR);
   endfunction

   function automatic logic is_outline(input logic [1:0] m);
      return (m == MODE_OUTLINE);
   endfunction

endpackage

// File: rtl/rect_draw_engine_raster_counter.sv
// Nested row-major x/y position counter. Coordinates are carried one bit wider
// than the screen coordinate so a rectangle end point can never wrap.
module raster_counter #(
   parameter int XW = 9,
   parameter int YW = 8
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          load,
   input  logic          enable,
   input  logic [XW-1:0] x_start,
   input  logic [XW-1:0] x_end,
   input  logic [YW-1:0] y_start,
   input  logic [YW-1:0] y_end,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);

   logic [XW-1:0] x_reg;
   logic [YW-1:0] y_reg;
   logic [XW-1:0] x_start_reg;
   logic [XW-1:0] x_end_reg;
   logic [YW-1:0] y_end_reg;
   logic          row_end;

   assign row_end = (x_reg == x_end_reg);
   assign last    = row_end && (y_reg == y_end_reg);
   assign x       = x_reg;
   assign y       = y_reg;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x_reg       <= '0;
         y_reg       <= '0;
         x_start_reg <= '0;
         x_end_reg   <= '0;
         y_end_reg   <= '0;
      end else if (load) begin
         x_reg       <= x_start;
         y_reg       <= y_start;
         x_start_reg <= x_start;
         x_end_reg   <= x_end;
         y_end_reg   <= y_end;
      end else if (enable) begin
         if (row_end) begin
            x_reg <= x_start_reg;
            y_reg <= y_reg + YW'(1);
         end else begin
            x_reg <= x_reg + XW'(1);
         end
      end
   end

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser feeding vga_adapter: one scan position per clock with
// registered x/y/colour/plot, clipping to the visible area and outline gating.
module rect_draw_engine
   import vga_draw_pkg::*;
#(
   parameter int X_WIDTH     = 8,
   parameter int Y_WIDTH     = 7,
   parameter int COLOUR_BITS = 3,
   parameter int X_MAX       = RES_160_X_MAX,
   parameter int Y_MAX       = RES_160_Y_MAX
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic [X_WIDTH-1:0]     x0,
   input  logic [Y_WIDTH-1:0]     y0,
   input  logic [X_WIDTH-1:0]     w,
   input  logic [Y_WIDTH-1:0]     h,
   input  logic [COLOUR_BITS-1:0] colour,
   output logic                   busy,
   output logic                   done,
   output logic [X_WIDTH-1:0]     x_out,
   output logic [Y_WIDTH-1:0]     y_out,
   output logic [COLOUR_BITS-1:0] colour_out,
   output logic                   plot
);

   localparam int XW = X_WIDTH + 1;
   localparam int YW = Y_WIDTH + 1;
   localparam logic [XW-1:0] X_LIM = XW'(X_MAX);
   localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX);

   draw_state_t state_reg, state_next;

   logic [1:0]             mode_reg;
   logic [COLOUR_BITS-1:0] colour_reg;
   logic [XW-1:0]          x0_reg, x_end_reg;
   logic [YW-1:0]          y0_reg, y_end_reg;

   logic          cnt_load, cnt_enable, cnt_last;
   logic [XW-1:0] cnt_x;
   logic [YW-1:0] cnt_y;
   logic [XW-1:0] ld_x_start, ld_x_end;
   logic [YW-1:0] ld_y_start, ld_y_end;
   logic          accept, visible, on_border, plot_next;
   logic [X_WIDTH-1:0] x_sat;
   logic [Y_WIDTH-1:0] y_sat;

   assign accept = (state_reg == IDLE) && start;

   // Load values: clear ignores the geometry; ends are one bit wider so they never wrap.
   always_comb begin
      ld_x_start = {1'b0, x0};
      ld_y_start = {1'b0, y0};
      ld_x_end   = {1'b0, x0} + {1'b0, w} - XW'(1);
      ld_y_end   = {1'b0, y0} + {1'b0, h} - YW'(1);
      if (is_clear(mode)) begin
         ld_x_start = '0;
         ld_y_start = '0;
         ld_x_end   = X_LIM;
         ld_y_end   = Y_LIM;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_load   = 1'b0;
      cnt_enable = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               cnt_load = 1'b1;
               if (!is_clear(mode) && ((w == '0) || (h == '0)))
                  state_next = FIN;
               else
                  state_next = SCAN;
            end
         end
         SCAN: begin
            cnt_enable = 1'b1;
            if (cnt_last)
               state_next = FIN;
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mode_reg   <= MODE_FILL;
         colour_reg <= '0;
         x0_reg     <= '0;
         y0_reg     <= '0;
         x_end_reg  <= '0;
         y_end_reg  <= '0;
      end else if (accept) begin
         mode_reg   <= mode;
         colour_reg <= colour;
         x0_reg     <= ld_x_start;
         y0_reg     <= ld_y_start;
         x_end_reg  <= ld_x_end;
         y_end_reg  <= ld_y_end;
      end
   end

   raster_counter #(
      .XW(XW),
      .YW(YW)
   ) u_raster (
      .clock   (clock),
      .resetn  (resetn),
      .load    (cnt_load),
      .enable  (cnt_enable),
      .x_start (ld_x_start),
      .x_end   (ld_x_end),
      .y_start (ld_y_start),
      .y_end   (ld_y_end),
      .x       (cnt_x),
      .y       (cnt_y),
      .last    (cnt_last)
   );

   assign visible   = (cnt_x <= X_LIM) && (cnt_y <= Y_LIM);
   assign on_border = (cnt_x == x0_reg) || (cnt_x == x_end_reg) ||
                      (cnt_y == y0_reg) || (cnt_y == y_end_reg);
   assign plot_next = visible && (!is_outline(mode_reg) || on_border);

   // Positions beyond the output width saturate rather than wrap to 0.
   assign x_sat = cnt_x[XW-1] ? '1 : cnt_x[X_WIDTH-1:0];
   assign y_sat = cnt_y[YW-1] ? '1 : cnt_y[Y_WIDTH-1:0];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x_out      <= '0;
         y_out      <= '0;
         colour_out <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_next == SCAN) || (state_reg == SCAN);
         done <= (state_reg == FIN);
         if (state_reg == SCAN) begin
            x_out      <= x_sat;
            y_out      <= y_sat;
            colour_out <= colour_reg;
            plot       <= plot_next;
         end else begin
            colour_out <= '0;
            plot       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed bench for rect_draw_engine: fill, zero size, outline, clipping,
// full clear and mid-draw start/reset behaviour.
module tb_rect_draw_engine;
   import vga_draw_pkg::*;

   logic       clock = 1'b0;
   logic       resetn;
   logic       start;
   logic [1:0] mode;
   logic [7:0] x0, w;
   logic [6:0] y0, h;
   logic [2:0] colour;
   logic       busy, done, plot;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   rect_draw_engine dut (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start),
      .mode       (mode),
      .x0         (x0),
      .y0         (y0),
      .w          (w),
      .h          (h),
      .colour     (colour),
      .busy       (busy),
      .done       (done),
      .x_out      (x_out),
      .y_out      (y_out),
      .colour_out (colour_out),
      .plot       (plot)
   );

   // Drives a command and returns 1ns after the accepting edge.
   task automatic do_start(input logic [1:0] m, input int ax, input int ay,
                           input int aw, input int ah, input logic [2:0] c);
      @(negedge clock);
      mode = m; x0 = 8'(ax); y0 = 7'(ay); w = 8'(aw); h = 7'(ah); colour = c;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      $display("cmd mode=%0d x0=%0d y0=%0d w=%0d h=%0d colour=%0d", m, ax, ay, aw, ah, c);
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; mode = MODE_FILL;
      x0 = '0; y0 = '0; w = '0; h = '0; colour = '0;
      #3;
      @(posedge clock);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (plot !== 1'b0) begin bad++; $display("FAIL reset_plot got=%b exp=0", plot); end
      total++; if (x_out !== 8'd0 || y_out !== 7'd0) begin
         bad++; $display("FAIL reset_xy got=(%0d,%0d) exp=(0,0)", x_out, y_out);
      end
      total++; if (colour_out !== 3'd0) begin bad++; $display("FAIL reset_colour got=%0d exp=0", colour_out); end
      @(negedge clock);
      resetn = 1'b1;
      $display("reset released");
   endtask

   task automatic test_fill();
      do_start(MODE_FILL, 10, 5, 2, 2, 3'b100);
      for (int k = 0; k < 4; k++) begin
         @(posedge clock); #1;
         total++;
         if (plot !== 1'b1 || x_out !== 8'(10 + k % 2) || y_out !== 7'(5 + k / 2) ||
             colour_out !== 3'd4 || busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL fill_pos%0d got=(%0d,%0d) plot=%b col=%0d busy=%b done=%b exp=(%0d,%0d) plot=1 col=4 busy=1 done=0",
                     k, x_out, y_out, plot, colour_out, busy, done, 10 + k % 2, 5 + k / 2);
         end
         $display("fill pos%0d (%0d,%0d) plot=%b", k, x_out, y_out, plot);
      end
      @(posedge clock); #1;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0 || colour_out !== 3'd0) begin
         bad++;
         $display("FAIL fill_done got done=%b busy=%b plot=%b col=%0d exp done=1 busy=0 plot=0 col=0",
                  done, busy, plot, colour_out);
      end
      @(posedge clock); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL fill_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_zero();
      int plots = 0;
      do_start(MODE_FILL, 30, 30, 0, 3, 3'b111);
      plots += int'(plot);
      @(posedge clock); #1;
      plots += int'(plot);
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
      @(posedge clock); #1;
      plots += int'(plot);
      total++; if (plots != 0) begin bad++; $display("FAIL zero_plots got=%0d exp=0", plots); end
      $display("zero size plots=%0d", plots);
   endtask

   task automatic test_outline();
      int plots = 0;
      logic exp_plot;
      do_start(MODE_OUTLINE, 20, 20, 3, 3, 3'b010);
      for (int k = 0; k < 9; k++) begin
         @(posedge clock); #1;
         exp_plot = !((20 + k % 3) == 21 && (20 + k / 3) == 21);
         plots += int'(plot);
         total++;
         if (plot !== exp_plot || x_out !== 8'(20 + k % 3) || y_out !== 7'(20 + k / 3)) begin
            bad++;
            $display("FAIL outline_pos%0d got=(%0d,%0d) plot=%b exp=(%0d,%0d) plot=%b",
                     k, x_out, y_out, plot, 20 + k % 3, 20 + k / 3, exp_plot);
         end
      end
      @(posedge clock); #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL outline_done got=%b exp=1", done); end
      total++; if (plots != 8) begin bad++; $display("FAIL outline_plots got=%0d exp=8", plots); end
      $display("outline plots=%0d", plots);
   endtask

   task automatic test_clip();
      int plots = 0;
      int ex, ey;
      logic exp_plot;
      do_start(MODE_FILL, 158, 119, 4, 2, 3'b101);
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         ex = 158 + k % 4; ey = 119 + k / 4;
         exp_plot = (ex <= 159) && (ey <= 119);
         plots += int'(plot);
         total++;
         if (plot !== exp_plot || x_out !== 8'(ex) || y_out !== 7'(ey)) begin
            bad++;
            $display("FAIL clip_pos%0d got=(%0d,%0d) plot=%b exp=(%0d,%0d) plot=%b",
                     k, x_out, y_out, plot, ex, ey, exp_plot);
         end
      end
      @(posedge clock); #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL clip_done got=%b exp=1", done); end
      total++; if (plots != 2) begin bad++; $display("FAIL clip_plots got=%0d exp=2", plots); end
      $display("clip plots=%0d", plots);
   endtask

   task automatic test_clear();
      int plots = 0;
      int errs  = 0;
      do_start(MODE_CLEAR, 50, 50, 3, 3, 3'b001);
      for (int k = 0; k < 19200; k++) begin
         @(posedge clock); #1;
         plots += int'(plot);
         if (plot !== 1'b1 || x_out !== 8'(k % 160) || y_out !== 7'(k / 160) || colour_out !== 3'd1)
            errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL clear_sequence got=%0d bad positions exp=0", errs); end
      total++; if (plots != 19200) begin bad++; $display("FAIL clear_plots got=%0d exp=19200", plots); end
      @(posedge clock); #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL clear_done got=%b exp=1", done); end
      $display("clear plots=%0d", plots);
   endtask

   task automatic test_back_to_back();
      int plots = 0;
      do_start(MODE_FILL, 0, 0, 4, 4, 3'b011);
      for (int k = 0; k < 16; k++) begin
         @(posedge clock); #1;
         start = 1'b0;
         plots += int'(plot);
         if (k == 5) begin
            @(negedge clock);
            mode = MODE_CLEAR; w = 8'd9; h = 7'd9;
            start = 1'b1;
         end
      end
      total++;
      if (x_out !== 8'd3 || y_out !== 7'd3) begin
         bad++; $display("FAIL ignore_last got=(%0d,%0d) exp=(3,3)", x_out, y_out);
      end
      @(posedge clock); #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ignore_done got=%b exp=1", done); end
      total++; if (plots != 16) begin bad++; $display("FAIL ignore_plots got=%0d exp=16", plots); end
      $display("mid-draw start ignored plots=%0d", plots);

      do_start(MODE_FILL, 40, 40, 5, 5, 3'b110);
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
      end
      @(negedge clock);
      resetn = 1'b0;
      #1;
      total++;
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || colour_out !== 3'd0) begin
         bad++;
         $display("FAIL async_reset got plot=%b busy=%b done=%b col=%0d exp all 0", plot, busy, done, colour_out);
      end
      @(posedge clock); #1;
      total++; if (plot !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_hold got plot=%b busy=%b exp 0 0", plot, busy);
      end
      @(negedge clock);
      resetn = 1'b1;
      $display("mid-draw reset applied and released");

      do_start(MODE_FILL, 1, 1, 1, 1, 3'b110);
      @(posedge clock); #1;
      total++;
      if (plot !== 1'b1 || x_out !== 8'd1 || y_out !== 7'd1 || colour_out !== 3'd6) begin
         bad++;
         $display("FAIL restart_pos got=(%0d,%0d) plot=%b col=%0d exp=(1,1) plot=1 col=6",
                  x_out, y_out, plot, colour_out);
      end
      @(posedge clock); #1;
      total++; if (done !== 1'b1 || plot !== 1'b0) begin
         bad++; $display("FAIL restart_done got done=%b plot=%b exp done=1 plot=0", done, plot);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_zero();
      test_outline();
      test_clip();
      test_clear();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
